// File: rtl/neuron_cfg_pkg.sv
// Shared definitions for the neuron configuration packet stream: header/end
// bytes, command type encoding and per-type packet lengths.
package neuron_cfg_pkg;

  localparam logic [7:0] HDR_WEIGHT = 8'hFF;
  localparam logic [7:0] HDR_REG    = 8'hFE;
  localparam logic [7:0] HDR_MODE   = 8'hFD;
  localparam logic [7:0] END_BYTE   = 8'h00;

  typedef enum logic [1:0] {
    CMD_WEIGHT  = 2'b00,
    CMD_REG     = 2'b01,
    CMD_MODE    = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_type_e;

  localparam logic [3:0] LEN_WEIGHT = 4'd10;
  localparam logic [3:0] LEN_REG    = 4'd8;
  localparam logic [3:0] LEN_MODE   = 4'd4;

  // Total bytes on the wire for a packet, header and end byte included.
  function automatic logic [3:0] pkt_len(input cmd_type_e t);
    case (t)
      CMD_WEIGHT: return LEN_WEIGHT;
      CMD_REG:    return LEN_REG;
      default:    return LEN_MODE;
    endcase
  endfunction

endpackage

// File: rtl/neuron_cfg_gap_timer.sv
// Loadable down-counter: after a load of N (N>0), expire is high during the
// Nth following cycle, then the counter parks at zero.
module neuron_cfg_gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/neuron_cfg_tx.sv
// Byte-serial configuration packet transmitter for one neuron.
// Optional NEURON_CFG_TX_STATS_EN adds a pkt_count output of completed packets.
module neuron_cfg_tx
  import neuron_cfg_pkg::*;
#(
  parameter int GAP    = 3,
  parameter int ADDR_W = 10,
  parameter int VAL_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [15:0]       cmd_ctrl,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [VAL_W-1:0]  cmd_value,
  output logic [7:0]        data,
  output logic              load_data,
  output logic              done,
  output logic              err
`ifdef NEURON_CFG_TX_STATS_EN
  ,
  output logic [15:0]       pkt_count
`endif
);

  // S_DONE behaves like S_IDLE (ready, can accept) but also raises done.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

  localparam bit         NO_GAP     = (GAP == 0);
  localparam logic [7:0] GAP_CYCLES = 8'(GAP);

  state_e            state_q, state_d;
  cmd_type_e         type_q;
  logic [15:0]       ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [VAL_W-1:0]  value_q;
  logic [3:0]        len_q;
  logic [3:0]        idx_q;
  logic [7:0]        sent_q;
  logic [7:0]        cur_byte;
  logic [15:0]       addr_ext;
  logic              err_q;
  logic              accept;
  logic              legal;
  logic              load_timer;
  logic              gap_expire;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_type_e'(cmd_type) != CMD_ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      type_q  <= CMD_WEIGHT;
      ctrl_q  <= '0;
      addr_q  <= '0;
      value_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if (accept && legal) begin
        type_q  <= cmd_type_e'(cmd_type);
        ctrl_q  <= cmd_ctrl;
        addr_q  <= cmd_addr;
        value_q <= cmd_value;
        len_q   <= pkt_len(cmd_type_e'(cmd_type));
        idx_q   <= '0;
      end else if (state_q == S_SEND) begin
        idx_q  <= idx_q + 4'd1;
        sent_q <= cur_byte;
      end
    end
  end

  // Byte mux over the latched command; anything past the payload is the end byte.
  always_comb begin
    cur_byte = END_BYTE;
    addr_ext = 16'(addr_q);
    case (type_q)
      CMD_WEIGHT: begin
        case (idx_q)
          4'd0:    cur_byte = HDR_WEIGHT;
          4'd1:    cur_byte = ctrl_q[7:0];
          4'd2:    cur_byte = ctrl_q[15:8];
          4'd3:    cur_byte = addr_ext[7:0];
          4'd4:    cur_byte = addr_ext[15:8];
          4'd5:    cur_byte = value_q[7:0];
          4'd6:    cur_byte = value_q[15:8];
          4'd7:    cur_byte = value_q[23:16];
          4'd8:    cur_byte = value_q[31:24];
          default: cur_byte = END_BYTE;
        endcase
      end
      CMD_REG: begin
        case (idx_q)
          4'd0:    cur_byte = HDR_REG;
          4'd1:    cur_byte = ctrl_q[7:0];
          4'd2:    cur_byte = ctrl_q[15:8];
          4'd3:    cur_byte = value_q[7:0];
          4'd4:    cur_byte = value_q[15:8];
          4'd5:    cur_byte = value_q[23:16];
          4'd6:    cur_byte = value_q[31:24];
          default: cur_byte = END_BYTE;
        endcase
      end
      default: begin
        case (idx_q)
          4'd0:    cur_byte = HDR_MODE;
          4'd1:    cur_byte = ctrl_q[7:0];
          4'd2:    cur_byte = ctrl_q[15:8];
          default: cur_byte = END_BYTE;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load_timer = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = (accept && legal) ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        if (NO_GAP) begin
          state_d = (idx_q == len_q - 4'd1) ? S_DONE : S_SEND;
        end else begin
          state_d    = S_WAIT;
          load_timer = 1'b1;
        end
      end
      S_WAIT: begin
        if (gap_expire) begin
          state_d = (idx_q == len_q) ? S_DONE : S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data      = 8'h00;
    load_data = 1'b0;
    done      = (state_q == S_DONE);
    err       = err_q;
    if (state_q == S_SEND) begin
      data      = cur_byte;
      load_data = 1'b1;
    end else if (state_q == S_WAIT) begin
      data = sent_q;
    end
  end

  neuron_cfg_gap_timer #(
    .W(8)
  ) u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_timer),
    .load_value(GAP_CYCLES),
    .expire    (gap_expire)
  );

`ifdef NEURON_CFG_TX_STATS_EN
  logic [15:0] pkt_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else if (state_q == S_DONE) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_neuron_cfg_tx.sv
// Self-checking bench for neuron_cfg_tx: one instance with GAP=0, one with GAP=3.
// Directed table vectors, corner sequences, then random packets against a byte-list model.
module tb_neuron_cfg_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic [1:0]  cmd_type  [2];
  logic [15:0] cmd_ctrl  [2];
  logic [9:0]  cmd_addr  [2];
  logic [31:0] cmd_value [2];

  logic       ready0, ld0, done0, err0;
  logic       ready1, ld1, done1, err1;
  logic [7:0] data0, data1;
`ifdef NEURON_CFG_TX_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int total  = 0;
  int passed = 0;
  int exp_count [2];

  neuron_cfg_tx #(.GAP(0), .ADDR_W(10), .VAL_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(ready0),
    .cmd_type(cmd_type[0]), .cmd_ctrl(cmd_ctrl[0]),
    .cmd_addr(cmd_addr[0]), .cmd_value(cmd_value[0]),
    .data(data0), .load_data(ld0), .done(done0), .err(err0)
`ifdef NEURON_CFG_TX_STATS_EN
    , .pkt_count(cnt0)
`endif
  );

  neuron_cfg_tx #(.GAP(3), .ADDR_W(10), .VAL_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(ready1),
    .cmd_type(cmd_type[1]), .cmd_ctrl(cmd_ctrl[1]),
    .cmd_addr(cmd_addr[1]), .cmd_value(cmd_value[1]),
    .data(data1), .load_data(ld1), .done(done1), .err(err1)
`ifdef NEURON_CFG_TX_STATS_EN
    , .pkt_count(cnt1)
`endif
  );

  typedef struct {
    int          inst;
    logic [1:0]  t;
    logic [15:0] ctrl;
    logic [9:0]  addr;
    logic [31:0] value;
    logic [79:0] bytes;
    int          len;
    int          done_cyc;
  } vec_t;

  vec_t vecs [4];

  // Packed view {err, ready, done, load_data, data} of one instance.
  function automatic logic [31:0] observe(input int inst);
    if (inst == 0) return {20'd0, err0, ready0, done0, ld0, data0};
    return {20'd0, err1, ready1, done1, ld1, data1};
  endfunction

  function automatic int gap_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  // Reference packet built from the byte-order rules as a plain list.
  function automatic void model_pkt(input logic [1:0] t, input logic [15:0] ctrl,
                                    input logic [9:0] addr, input logic [31:0] value,
                                    output logic [79:0] bytes, output int len);
    logic [7:0] q [$];
    q = {};
    if (t == 2'b00) q.push_back(8'hFF);
    else if (t == 2'b01) q.push_back(8'hFE);
    else q.push_back(8'hFD);
    q.push_back(ctrl[7:0]);
    q.push_back(ctrl[15:8]);
    if (t == 2'b00) begin
      q.push_back(addr[7:0]);
      q.push_back({6'b0, addr[9:8]});
    end
    if (t != 2'b10) begin
      for (int b = 0; b < 4; b++) q.push_back(value[8*b +: 8]);
    end
    q.push_back(8'h00);
    bytes = '0;
    foreach (q[k]) bytes[8*k +: 8] = q[k];
    len = q.size();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
  endtask

  // Called just after a negedge; the handshake completes on the next posedge.
  task automatic applyStimulus(input int inst, input logic [1:0] t, input logic [15:0] ctrl,
                               input logic [9:0] addr, input logic [31:0] value);
    logic [31:0] obs;
    cmd_valid[inst] = 1'b1;
    cmd_type[inst]  = t;
    cmd_ctrl[inst]  = ctrl;
    cmd_addr[inst]  = addr;
    cmd_value[inst] = value;
    obs = observe(inst);
    checkOutput($sformatf("ready before accept i%0d", inst), {31'd0, obs[10]}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid[inst] = 1'b0;
    cmd_type[inst]  = 2'($urandom);
    cmd_ctrl[inst]  = 16'($urandom);
    cmd_addr[inst]  = 10'($urandom);
    cmd_value[inst] = $urandom;
  endtask

  task automatic run_packet(input int inst, input logic [1:0] t, input logic [15:0] ctrl,
                            input logic [9:0] addr, input logic [31:0] value,
                            input logic [79:0] exp_bytes, input int exp_len,
                            input int exp_done_cyc, input string tag);
    int gap;
    int span;
    logic exp_ld, exp_end;
    logic [7:0] exp_data;
    gap  = gap_of(inst);
    span = exp_len * (gap + 1);
    applyStimulus(inst, t, ctrl, addr, value);
    for (int c = 1; c <= exp_done_cyc; c++) begin
      @(negedge clk);
      exp_ld   = (c <= span) && (((c - 1) % (gap + 1)) == 0);
      exp_data = (c <= span) ? exp_bytes[8*((c - 1) / (gap + 1)) +: 8] : 8'h00;
      exp_end  = (c == exp_done_cyc);
      checkOutput($sformatf("%s i%0d cyc %0d", tag, inst, c), observe(inst),
                  {20'd0, 1'b0, exp_end, exp_end, exp_ld, exp_data});
    end
    exp_count[inst]++;
  endtask

  task automatic run_illegal(input int inst);
    applyStimulus(inst, 2'b11, 16'($urandom), 10'($urandom), $urandom);
    @(negedge clk);
    checkOutput($sformatf("illegal err i%0d", inst), observe(inst), 32'h400 | 32'h800);
    @(negedge clk);
    checkOutput($sformatf("illegal after i%0d", inst), observe(inst), 32'h400);
  endtask

  initial begin
    logic [1:0]  t;
    logic [15:0] ctrl;
    logic [9:0]  addr;
    logic [31:0] value;
    logic [79:0] bytes;
    int          len;
    int          inst;

    vecs[0] = '{1, 2'b00, 16'h3801, 10'd1,   32'h00050403, 80'h0000_0504_0300_0138_01FF, 10, 41};
    vecs[1] = '{1, 2'b01, 16'h003F, 10'd0,   32'h040302AF, 80'h0000_0004_0302_AF00_3FFE, 8,  33};
    vecs[2] = '{0, 2'b10, 16'h0001, 10'd0,   32'h0,        80'h0000_0000_0000_0000_01FD, 4,  5};
    vecs[3] = '{0, 2'b00, 16'hABCD, 10'h3FF, 32'hDEADBEEF, 80'h00DE_ADBE_EF03_FFAB_CDFF, 10, 11};

    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_type[i]  = 2'b00;
      cmd_ctrl[i]  = '0;
      cmd_addr[i]  = '0;
      cmd_value[i] = '0;
      exp_count[i] = 0;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset i0", observe(0), 32'h400);
    checkOutput("reset i1", observe(1), 32'h400);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed table vectors");
    for (int v = 0; v < 4; v++) begin
      run_packet(vecs[v].inst, vecs[v].t, vecs[v].ctrl, vecs[v].addr, vecs[v].value,
                 vecs[v].bytes, vecs[v].len, vecs[v].done_cyc, $sformatf("vec%0d", v));
    end

    $display("[TB] illegal command then weight");
    run_illegal(1);
    run_packet(1, vecs[0].t, vecs[0].ctrl, vecs[0].addr, vecs[0].value,
               vecs[0].bytes, vecs[0].len, vecs[0].done_cyc, "post-illegal");

    $display("[TB] reset mid-packet");
    applyStimulus(1, 2'b00, 16'h3801, 10'd1, 32'h00050403);
    repeat (13) @(negedge clk);
    checkOutput("rst 4th strobe", observe(1), 32'h101);
    @(negedge clk);
    checkOutput("rst hold byte", observe(1), 32'h001);
    rst_n = 1'b0;
    #1;
    checkOutput("rst clear i1", observe(1), 32'h400);
    checkOutput("rst clear i0", observe(0), 32'h400);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count[0] = 0;
    exp_count[1] = 0;
    run_packet(1, vecs[0].t, vecs[0].ctrl, vecs[0].addr, vecs[0].value,
               vecs[0].bytes, vecs[0].len, vecs[0].done_cyc, "post-reset");

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      inst = int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        run_illegal(inst);
      end else begin
        t     = 2'($urandom_range(0, 2));
        ctrl  = 16'($urandom);
        addr  = 10'($urandom);
        value = $urandom;
        model_pkt(t, ctrl, addr, value, bytes, len);
        run_packet(inst, t, ctrl, addr, value, bytes, len,
                   len * (gap_of(inst) + 1) + 1, $sformatf("rnd%0d", i));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef NEURON_CFG_TX_STATS_EN
    checkOutput("pkt_count i0", {16'd0, cnt0}, 32'(exp_count[0] & 16'hFFFF));
    checkOutput("pkt_count i1", {16'd0, cnt1}, 32'(exp_count[1] & 16'hFFFF));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
